// File: rtl/z_writeback_seq_if.sv
// Purpose: groups the ALU-result handshake and the shared-bus writeback signals of z_writeback_seq.
// Latency: none, this is wiring only.
// Backpressure: in_valid/in_ready on the result side; bus_req/bus_gnt on the bus side.
// Signals: in_valid/in_ready/is_wide/dest/zhi/zlo (ALU result), bus_req/bus_gnt/bus_data (shared bus),
//          rf_we/rf_addr/lo_we/hi_we (register file enables), busy/err (status).
// Modports: master = the writeback block itself, slave = whatever sits around it (ALU, bus, register file).
interface z_writeback_seq_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic              is_wide;
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] zhi;
    logic [DATA_W-1:0] zlo;
    logic              bus_req;
    logic              bus_gnt;
    logic [DATA_W-1:0] bus_data;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_addr;
    logic              lo_we;
    logic              hi_we;
    logic              busy;
    logic              err;

    modport master (
        input  in_valid, is_wide, dest, zhi, zlo, bus_gnt,
        output in_ready, bus_req, bus_data, rf_we, rf_addr, lo_we, hi_we, busy, err
    );

    modport slave (
        output in_valid, is_wide, dest, zhi, zlo, bus_gnt,
        input  in_ready, bus_req, bus_data, rf_we, rf_addr, lo_we, hi_we, busy, err
    );
endinterface

// File: rtl/z_writeback_seq.sv
// Purpose: captures the ALU zhi/zlo result pair and writes it back over the shared bus
//          (narrow: ZLO -> general register; wide: ZLO -> LO then ZHI -> HI).
// Latency: accept in T, earliest transfer in T+1 (wide HI in T+2); in_ready returns the cycle after the last transfer.
// Backpressure: in_ready is high only while idle; a bus grant wait longer than TIMEOUT aborts and pulses err.
// Ports: clock, reset (sync, active high), wb (z_writeback_seq_if.master) carrying all handshake/bus signals.
module z_writeback_seq #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                clock,
    input  logic                reset,
    z_writeback_seq_if.master   wb
);
    typedef enum logic [1:0] {IDLE, REQ_LO, REQ_HI} state_t;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] zhi_q, zhi_d;
    logic [DATA_W-1:0] zlo_q, zlo_d;
    logic [ADDR_W-1:0] dest_q, dest_d;
    logic              wide_q, wide_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              err_q, err_d;

    logic              in_ready;
    logic              bus_req;
    logic [DATA_W-1:0] bus_data;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_addr;
    logic              lo_we;
    logic              hi_we;
    logic              busy;

    always_comb begin
        state_d  = state_q;
        zhi_d    = zhi_q;
        zlo_d    = zlo_q;
        dest_d   = dest_q;
        wide_d   = wide_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;
        in_ready = 1'b0;
        bus_req  = 1'b0;
        bus_data = '0;
        rf_we    = 1'b0;
        rf_addr  = '0;
        lo_we    = 1'b0;
        hi_we    = 1'b0;
        busy     = 1'b0;
        // Outputs are combinational from the state, so reset must gate them
        // directly: a reset landing mid-writeback may not leak an enable.
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    in_ready = 1'b1;
                    if (wb.in_valid) begin
                        zhi_d   = wb.zhi;
                        zlo_d   = wb.zlo;
                        dest_d  = wb.dest;
                        wide_d  = wb.is_wide;
                        cnt_d   = '0;
                        state_d = REQ_LO;
                    end
                end
                REQ_LO: begin
                    bus_req = 1'b1;
                    busy    = 1'b1;
                    if (wb.bus_gnt) begin
                        bus_data = zlo_q;
                        if (wide_q) begin
                            lo_we   = 1'b1;
                            cnt_d   = '0;
                            state_d = REQ_HI;
                        end else begin
                            rf_we   = 1'b1;
                            rf_addr = dest_q;
                            state_d = IDLE;
                        end
                    end else if (cnt_q == TMO) begin
                        // A grant arriving on the limit cycle is taken above, so
                        // the abort only fires when the grant is still absent.
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                REQ_HI: begin
                    bus_req = 1'b1;
                    busy    = 1'b1;
                    if (wb.bus_gnt) begin
                        bus_data = zhi_q;
                        hi_we    = 1'b1;
                        state_d  = IDLE;
                    end else if (cnt_q == TMO) begin
                        // The LO half is already written; only the HI write is lost.
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            zhi_q   <= '0;
            zlo_q   <= '0;
            dest_q  <= '0;
            wide_q  <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            zhi_q   <= zhi_d;
            zlo_q   <= zlo_d;
            dest_q  <= dest_d;
            wide_q  <= wide_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign wb.in_ready = in_ready;
    assign wb.bus_req  = bus_req;
    assign wb.bus_data = bus_data;
    assign wb.rf_we    = rf_we;
    assign wb.rf_addr  = rf_addr;
    assign wb.lo_we    = lo_we;
    assign wb.hi_we    = hi_we;
    assign wb.busy     = busy;
    assign wb.err      = err_q & ~reset;
endmodule

// File: tb/tb_z_writeback_seq.sv
// Purpose: checks z_writeback_seq with TIMEOUT=15 and TIMEOUT=3 instances driven by the same inputs.
// Latency: a transfer-list model predicts outputs every cycle; directed literals pin key cycles.
// Backpressure: bus_gnt is scripted per cycle to exercise delayed grants, timeouts and the limit-cycle grant.
module tb_z_writeback_seq;
    logic        clock;
    logic        rst;
    logic        vld, wide, gnt;
    logic [3:0]  dst;
    logic [31:0] zh, zl;

    int checks = 0;
    int errors = 0;

    z_writeback_seq_if #(.DATA_W(32), .ADDR_W(4)) if15 ();
    z_writeback_seq_if #(.DATA_W(32), .ADDR_W(4)) if3 ();

    assign if15.in_valid = vld;
    assign if15.is_wide  = wide;
    assign if15.dest     = dst;
    assign if15.zhi      = zh;
    assign if15.zlo      = zl;
    assign if15.bus_gnt  = gnt;
    assign if3.in_valid  = vld;
    assign if3.is_wide   = wide;
    assign if3.dest      = dst;
    assign if3.zhi       = zh;
    assign if3.zlo       = zl;
    assign if3.bus_gnt   = gnt;

    z_writeback_seq #(.DATA_W(32), .ADDR_W(4), .TIMEOUT(15)) u_t15 (.clock(clock), .reset(rst), .wb(if15));
    z_writeback_seq #(.DATA_W(32), .ADDR_W(4), .TIMEOUT(3))  u_t3  (.clock(clock), .reset(rst), .wb(if3));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: per instance, the list of transfers still owed (kind 0=reg, 1=LO, 2=HI),
    // how long the head transfer has waited, and whether an err pulse is due.
    int          n      [2];
    int          waited [2];
    bit          errp   [2];
    int          kind   [2][2];
    logic [31:0] dat    [2][2];
    logic [3:0]  adr    [2][2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            n[i] = 0; waited[i] = 0; errp[i] = 1'b0;
        end
    end

    task automatic model_cycle(input int i, input int tmo, input string p,
                               input logic a_ready, input logic a_req, input logic a_busy,
                               input logic a_err, input logic a_rf, input logic a_lo,
                               input logic a_hi, input logic [3:0] a_addr, input logic [31:0] a_data);
        logic e_ready, e_req, e_rf, e_lo, e_hi, e_err;
        logic [3:0]  e_addr;
        logic [31:0] e_data;
        e_ready = !rst && n[i] == 0;
        e_req   = !rst && n[i] > 0;
        e_err   = !rst && errp[i];
        e_rf = 1'b0; e_lo = 1'b0; e_hi = 1'b0; e_addr = '0; e_data = '0;
        if (e_req && gnt) begin
            e_data = dat[i][0];
            if (kind[i][0] == 0) begin
                e_rf = 1'b1; e_addr = adr[i][0];
            end else if (kind[i][0] == 1) e_lo = 1'b1;
            else e_hi = 1'b1;
        end
        chk({p, ".in_ready"}, 64'(a_ready), 64'(e_ready));
        chk({p, ".bus_req"},  64'(a_req),   64'(e_req));
        chk({p, ".busy"},     64'(a_busy),  64'(e_req));
        chk({p, ".err"},      64'(a_err),   64'(e_err));
        chk({p, ".rf_we"},    64'(a_rf),    64'(e_rf));
        chk({p, ".lo_we"},    64'(a_lo),    64'(e_lo));
        chk({p, ".hi_we"},    64'(a_hi),    64'(e_hi));
        chk({p, ".rf_addr"},  64'(a_addr),  64'(e_addr));
        chk({p, ".bus_data"}, 64'(a_data),  64'(e_data));
        chk({p, ".one_enable"}, 64'(int'(a_rf) + int'(a_lo) + int'(a_hi) <= 1), 64'(1));
        if (rst) begin
            n[i] = 0; waited[i] = 0; errp[i] = 1'b0;
        end else begin
            errp[i] = 1'b0;
            if (n[i] == 0) begin
                if (vld) begin
                    if (wide) begin
                        kind[i][0] = 1; dat[i][0] = zl; adr[i][0] = '0;
                        kind[i][1] = 2; dat[i][1] = zh; adr[i][1] = '0;
                        n[i] = 2;
                    end else begin
                        kind[i][0] = 0; dat[i][0] = zl; adr[i][0] = dst;
                        n[i] = 1;
                    end
                    waited[i] = 0;
                end
            end else if (gnt) begin
                kind[i][0] = kind[i][1]; dat[i][0] = dat[i][1]; adr[i][0] = adr[i][1];
                n[i] = n[i] - 1;
                waited[i] = 0;
            end else if (waited[i] == tmo) begin
                n[i] = 0; errp[i] = 1'b1;
            end else begin
                waited[i] = waited[i] + 1;
            end
        end
    endtask

    always @(negedge clock) begin
        model_cycle(0, 15, "t15", if15.in_ready, if15.bus_req, if15.busy, if15.err, if15.rf_we,
                    if15.lo_we, if15.hi_we, if15.rf_addr, if15.bus_data);
        model_cycle(1, 3, "t3", if3.in_ready, if3.bus_req, if3.busy, if3.err, if3.rf_we,
                    if3.lo_we, if3.hi_we, if3.rf_addr, if3.bus_data);
    end

    task automatic next_cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic apply(input logic v, input logic w, input logic [3:0] d,
                         input logic [31:0] h, input logic [31:0] l, input logic g);
        vld = v; wide = w; dst = d; zh = h; zl = l; gnt = g;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        vld = 1'b0; wide = 1'b0; gnt = 1'b0; dst = '0; zh = '0; zl = '0;
        // reset for two cycles
        next_cyc();
        apply(0, 0, 0, 0, 0, 0);
        chk("rst.in_ready", 64'(if15.in_ready), 64'(0));
        chk("rst.bus_req",  64'(if15.bus_req), 64'(0));
        next_cyc();
        rst = 1'b0;
        apply(0, 0, 0, 0, 0, 0);
        chk("idle.in_ready", 64'(if15.in_ready), 64'(1));
        chk("idle.busy",     64'(if15.busy), 64'(0));

        // narrow op, grant tied high
        next_cyc(); apply(1, 0, 4'd5, 32'h0, 32'h7, 1);
        next_cyc(); apply(0, 0, 0, 0, 0, 1);
        chk("narrow.rf_we",   64'(if15.rf_we), 64'(1));
        chk("narrow.rf_addr", 64'(if15.rf_addr), 64'(5));
        chk("narrow.data",    64'(if15.bus_data), 64'h7);
        chk("narrow.lo_we",   64'(if15.lo_we), 64'(0));
        next_cyc(); apply(0, 0, 0, 0, 0, 1);
        chk("narrow.ready_after", 64'(if15.in_ready), 64'(1));

        // wide op (-1 x 2)
        next_cyc(); apply(1, 1, 4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1);
        next_cyc(); apply(0, 0, 0, 0, 0, 1);
        chk("wide.lo_we", 64'(if15.lo_we), 64'(1));
        chk("wide.lo_data", 64'(if15.bus_data), 64'hFFFF_FFFE);
        next_cyc(); apply(0, 0, 0, 0, 0, 1);
        chk("wide.hi_we", 64'(if15.hi_we), 64'(1));
        chk("wide.hi_data", 64'(if15.bus_data), 64'hFFFF_FFFF);
        chk("wide.rf_we", 64'(if15.rf_we), 64'(0));
        next_cyc(); apply(0, 0, 0, 0, 0, 0);

        // delayed grant: 4 cycles without grant, then grant
        next_cyc(); apply(1, 0, 4'd3, 32'h0, 32'h1234, 0);
        for (int k = 0; k < 4; k++) begin
            next_cyc(); apply(0, 0, 0, 0, 0, 0);
            chk("delay.bus_req", 64'(if15.bus_req), 64'(1));
            chk("delay.no_rf_we", 64'(if15.rf_we), 64'(0));
        end
        next_cyc(); apply(0, 0, 0, 0, 0, 1);
        chk("delay.rf_we", 64'(if15.rf_we), 64'(1));
        chk("delay.data",  64'(if15.bus_data), 64'h1234);
        chk("delay.addr",  64'(if15.rf_addr), 64'(3));
        chk("delay.t3_err", 64'(if3.err), 64'(1));
        chk("delay.t3_rf_we", 64'(if3.rf_we), 64'(0));
        next_cyc(); apply(0, 0, 0, 0, 0, 0);
        chk("delay.t15_err", 64'(if15.err), 64'(0));

        // timeout in REQ_HI on the TIMEOUT=3 instance
        next_cyc(); apply(1, 1, 4'd0, 32'hCAFE_0001, 32'hBEEF_0002, 1);
        next_cyc(); apply(0, 0, 0, 0, 0, 1);
        chk("tmo.lo_we", 64'(if3.lo_we), 64'(1));
        for (int k = 0; k < 4; k++) begin
            next_cyc(); apply(0, 0, 0, 0, 0, 0);
            chk("tmo.waiting", 64'(if3.bus_req), 64'(1));
        end
        next_cyc(); apply(0, 0, 0, 0, 0, 1);
        chk("tmo.err",   64'(if3.err), 64'(1));
        chk("tmo.hi_we", 64'(if3.hi_we), 64'(0));
        chk("tmo.busy",  64'(if3.busy), 64'(0));
        chk("tmo.t15_hi_we", 64'(if15.hi_we), 64'(1));
        next_cyc(); apply(0, 0, 0, 0, 0, 0);
        chk("tmo.err_one_cycle", 64'(if3.err), 64'(0));

        // grant on the cycle the counter reaches the limit
        next_cyc(); apply(1, 1, 4'd0, 32'h1111_2222, 32'h3333_4444, 1);
        next_cyc(); apply(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            next_cyc(); apply(0, 0, 0, 0, 0, 0);
        end
        next_cyc(); apply(0, 0, 0, 0, 0, 1);
        chk("limit.hi_we", 64'(if3.hi_we), 64'(1));
        chk("limit.data",  64'(if3.bus_data), 64'h1111_2222);
        next_cyc(); apply(0, 0, 0, 0, 0, 0);
        chk("limit.no_err", 64'(if3.err), 64'(0));

        // in_valid while busy is ignored
        next_cyc(); apply(1, 0, 4'd2, 32'h0, 32'hAAAA, 0);
        next_cyc(); apply(1, 0, 4'd9, 32'h0, 32'hBBBB, 0);
        chk("busy.in_ready", 64'(if15.in_ready), 64'(0));
        next_cyc(); apply(0, 0, 0, 0, 0, 1);
        chk("busy.addr", 64'(if15.rf_addr), 64'(2));
        chk("busy.data", 64'(if15.bus_data), 64'hAAAA);
        next_cyc(); apply(0, 0, 0, 0, 0, 1);
        chk("busy.no_second", 64'(if15.rf_we), 64'(0));

        // reset while in REQ_HI with grant
        next_cyc(); apply(1, 1, 4'd0, 32'h5555_0000, 32'h0000_AAAA, 1);
        next_cyc(); apply(0, 0, 0, 0, 0, 1);
        chk("rstmid.lo_we", 64'(if15.lo_we), 64'(1));
        next_cyc();
        rst = 1'b1;
        apply(0, 0, 0, 0, 0, 1);
        chk("rstmid.hi_we",    64'(if15.hi_we), 64'(0));
        chk("rstmid.bus_data", 64'(if15.bus_data), 64'(0));
        chk("rstmid.in_ready", 64'(if15.in_ready), 64'(0));
        next_cyc();
        rst = 1'b0;
        apply(0, 0, 0, 0, 0, 1);
        chk("rstmid.ready_after", 64'(if15.in_ready), 64'(1));
        chk("rstmid.no_hi_we",    64'(if15.hi_we), 64'(0));
        for (int k = 0; k < 3; k++) begin
            next_cyc(); apply(0, 0, 0, 0, 0, 1);
        end
        next_cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
